// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// debug view of the control state.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DIV  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    state_e state;
    logic   div_busy;
  } dbg_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bundle of the sequential ALU. A transfer happens on a rising
// clk edge where valid && ready; the producer holds its payload until then.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  import seq_alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             carry;
  logic             zero;
  logic             dbz;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, remainder, carry, zero, dbz
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, remainder, carry, zero, dbz
  );
endinterface

// File: rtl/seq_alu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clk, WIDTH steps.
// done is high during the final step; quotient/remainder carry that step's result.
module seq_alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_n, quo_n;

  // quo_q starts as the dividend and is shifted out MSB-first while the
  // quotient bits shift in from the bottom.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs_q};
    rem_n   = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], fits};
  end

  assign busy      = cnt_q != '0;
  assign done      = cnt_q == CNT_W'(1);
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(WIDTH);
    end else if (busy) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Registered 4-op ALU (ADD, SUB, DIV, AND) with valid/ready on both sides.
// Single-cycle ops finish on the accepting edge; DIV runs the iterative divider.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_alu_if.slave       bus,
  output dbg_t           dbg
);
  state_e           state_q, state_d;
  logic             accept, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] result_q, rem_q;
  logic             carry_q, zero_q, dbz_q;

  seq_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    accept    = (state_q == S_IDLE) && bus.in_valid;
    div_start = accept && (bus.op == OP_DIV) && (bus.b != '0);
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};
    unique case (state_q)
      S_IDLE:  if (accept) state_d = div_start ? S_DIV : S_DONE;
      S_DIV:   if (div_done) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers only load on accept or divider completion, so they hold
  // through backpressure and keep their last value after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        unique case (bus.op)
          OP_ADD: begin
            result_q <= sum[WIDTH-1:0];
            rem_q    <= '0;
            carry_q  <= sum[WIDTH];
            zero_q   <= sum[WIDTH-1:0] == '0;
            dbz_q    <= 1'b0;
          end
          OP_SUB: begin
            result_q <= diff[WIDTH-1:0];
            rem_q    <= '0;
            carry_q  <= diff[WIDTH];
            zero_q   <= diff[WIDTH-1:0] == '0;
            dbz_q    <= 1'b0;
          end
          OP_AND: begin
            result_q <= bus.a & bus.b;
            rem_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= (bus.a & bus.b) == '0;
            dbz_q    <= 1'b0;
          end
          OP_DIV: begin
            if (bus.b == '0) begin
              result_q <= '1;
              rem_q    <= bus.a;
              carry_q  <= 1'b0;
              zero_q   <= 1'b0;
              dbz_q    <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (state_q == S_DIV && div_done) begin
        result_q <= div_quo;
        rem_q    <= div_rem;
        carry_q  <= 1'b0;
        zero_q   <= div_quo == '0;
        dbz_q    <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.result    = result_q;
  assign bus.remainder = rem_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.dbz       = dbz_q;
  assign dbg.state     = state_q;
  assign dbg.div_busy  = div_busy;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for single operations plus
// hand-written backpressure and reset-during-divide sequences.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  dbg_t dbg;
  int   nchk = 0;
  int   nerr = 0;

  seq_alu_if #(.WIDTH(W)) bus();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .dbg   (dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         c;
    logic         z;
    logic         d;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(op_e op, logic [W-1:0] a, logic [W-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid; operands are scrambled
  // meanwhile to show they are ignored once accepted.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      chk("div_busy", 32'(dbg.div_busy), 32'd1);
      bus.a = W'($urandom_range(0, 255));
      bus.b = W'($urandom_range(0, 255));
      bus.op = op_e'($urandom_range(0, 3));
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(vec_t v);
    int lat;
    send(v.op, v.a, v.b);
    wait_out(lat);
    chk("latency", 32'(lat), 32'(v.lat));
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("result", 32'(bus.result), 32'(v.res));
    chk("remainder", 32'(bus.remainder), 32'(v.rem));
    chk("carry", 32'(bus.carry), 32'(v.c));
    chk("zero", 32'(bus.zero), 32'(v.z));
    chk("dbz", 32'(bus.dbz), 32'(v.d));
    tick();
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_result_held", 32'(bus.result), 32'(v.res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = OP_ADD;
    bus.out_ready = 1'b1;

    //      op      a      b      res    rem    c     z     d     lat
    vecs.push_back('{OP_ADD, 8'h33, 8'h04, 8'h37, 8'h00, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0});
    vecs.push_back('{OP_SUB, 8'hFF, 8'h01, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{OP_SUB, 8'h01, 8'h02, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{OP_DIV, 8'hF0, 8'h0F, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, W});
    vecs.push_back('{OP_DIV, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, W});
    vecs.push_back('{OP_DIV, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1, 0});
    vecs.push_back('{OP_AND, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{OP_AND, 8'hF3, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{OP_DIV, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0, W});
    vecs.push_back('{OP_DIV, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, W});
    vecs.push_back('{OP_SUB, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0});

    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_flags", {29'd0, bus.carry, bus.zero, bus.dbz}, 32'd0);
    chk("rst_state", 32'(dbg.state), 32'(S_IDLE));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Backpressure: result held, new operands refused while DONE.
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h10, 8'h20);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_result", 32'(bus.result), 32'h30);
      bus.in_valid = 1'b1;
      bus.a = 8'h01;
      bus.b = 8'h01;
      bus.op = OP_SUB;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_hold_result", 32'(bus.result), 32'h30);
    chk("bp_hold_flags", {29'd0, bus.carry, bus.zero, bus.dbz}, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_result", 32'(bus.result), 32'h30);

    // Reset during the 4th divide cycle discards the division.
    send(OP_DIV, 8'hF0, 8'h0F);
    chk("rd_state", 32'(dbg.state), 32'(S_DIV));
    tick();
    tick();
    tick();
    chk("rd_still_div", 32'(dbg.state), 32'(S_DIV));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rd_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rd_result", 32'(bus.result), 32'd0);
    chk("rd_remainder", 32'(bus.remainder), 32'd0);
    chk("rd_flags", {29'd0, bus.carry, bus.zero, bus.dbz}, 32'd0);
    chk("rd_div_busy", 32'(dbg.div_busy), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("rd_no_output", 32'(bus.out_valid), 32'd0);
    end
    run_vec('{OP_ADD, 8'h01, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 0});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
